// File: rtl/weight_loader_pkg.sv
// Shared types for the weight loader: the FSM state enum, the default weight width
// and a helper that returns the counter width.
package weight_loader_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } wl_state_e;

  // The counter is at least one bit wide, so ROWS=1 still gets a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Weight-row stream into the loader. Each beat is one row, with column c in s_data[c*DW +: DW].
// A beat transfers when s_valid and s_ready are both high at a rising edge.
interface weight_loader_if
  import weight_loader_pkg::*;
#(
  parameter int COLS = 8,
  parameter int DW   = DW_DEFAULT
) ();

  logic                 s_valid;
  logic                 s_ready;
  logic [COLS*DW-1:0]   s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/weight_loader_row_buffer.sv
// Tile buffer of ROWS x W raw bits. It has one registered write port and one combinational read port.
// The contents are not reset, because every row is written before it is read.
module weight_row_buffer #(
  parameter int ROWS = 8,
  parameter int W    = 64,
  parameter int AW   = 3
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [ROWS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/weight_loader.sv
// Buffers a ROWS-row weight tile, then shifts it down the PE columns bottom row first. Start to done is 1+fill+ROWS+1 cycles.
// FILL stalls on s_valid gaps. SHIFT never stalls. All outputs are registered.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = DW_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                start,
  weight_loader_if.slave      s_if,
  output logic [COLS*DW-1:0]  w_data,
  output logic                w_en,
  output logic                array_en,
  output logic                busy,
  output logic                done
);

  localparam int            CW          = cnt_w(ROWS);
  localparam logic [CW-1:0] LAST        = CW'(ROWS - 1);
  localparam logic [CW-1:0] SECOND_LAST = CW'(ROWS - 2);

  wl_state_e            state_q, state_d;
  logic [CW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]        shift_cnt_q, shift_cnt_d;
  logic                 s_ready_q, s_ready_d;
  logic                 w_en_q, w_en_d;
  logic                 array_en_q, array_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [COLS*DW-1:0]   w_data_q, w_data_d;

  logic                 beat, last_beat, last_shift;
  logic [CW-1:0]        rd_addr;
  logic [COLS*DW-1:0]   rd_data;

  assign beat       = (state_q == FILL) && s_if.s_valid && s_ready_q;
  assign last_beat  = beat && (fill_cnt_q == LAST);
  assign last_shift = (state_q == SHIFT) && (shift_cnt_q == LAST);
  // This read address serves the next shift cycle. The final row of the tile bypasses the buffer.
  assign rd_addr    = SECOND_LAST - shift_cnt_q;

  weight_row_buffer #(
    .ROWS (ROWS),
    .W    (COLS*DW),
    .AW   (CW)
  ) u_buf (
    .clk_i     (CLK),
    .wr_en_i   (beat),
    .wr_addr_i (fill_cnt_q),
    .wr_data_i (s_if.s_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      shift_cnt_q <= '0;
      s_ready_q   <= 1'b0;
      w_en_q      <= 1'b0;
      array_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      s_ready_q   <= s_ready_d;
      w_en_q      <= w_en_d;
      array_en_q  <= array_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_data_q    <= w_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    shift_cnt_d = shift_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end
      FILL: begin
        if (last_beat) begin
          state_d     = SHIFT;
          fill_cnt_d  = '0;
          shift_cnt_d = '0;
        end else if (beat) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_d     = DONE;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each registered output lines up with the state it belongs to.
  always_comb begin
    s_ready_d  = (state_d == FILL);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    w_en_d     = (state_d == SHIFT);
    array_en_d = (state_d == SHIFT);
    w_data_d   = '0;
    if (state_d == SHIFT) begin
      w_data_d = (state_q == FILL) ? s_if.s_data : rd_data;
    end
  end

  assign s_if.s_ready = s_ready_q;
  assign w_data       = w_data_q;
  assign w_en         = w_en_q;
  assign array_en     = array_en_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_weight_loader.sv
// Randomised scoreboard bench for weight_loader with ROWS=COLS=4, driving a 4x4 PE shift-chain model.
// Stimulus pushes the expected w_data sequence, done cycle and tile. A negedge monitor pops and compares them.
module tb_weight_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic                start;
  logic [COLS*DW-1:0]  w_data;
  logic                w_en, array_en, busy, done;

  weight_loader_if #(.COLS(COLS), .DW(DW)) s_if ();

  weight_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .start    (start),
    .s_if     (s_if),
    .w_data   (w_data),
    .w_en     (w_en),
    .array_en (array_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  logic [31:0]            exp_w[$];
  int                     exp_done[$];
  logic [3:0][31:0]       exp_tile[$];
  logic [7:0]             pe [ROWS][COLS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The monitor samples on the falling edge. The PE chain copies in_weight_above on every EN&W_EN cycle.
  logic [31:0]      mon_e;
  logic [3:0][31:0] mon_t;
  int               mon_d;
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("array_en_follows_w_en", 32'(array_en), 32'(w_en));
      if (w_en) begin
        if (exp_w.size() == 0) begin
          chk("w_en_unexpected", 32'(w_en), 32'd0);
        end else begin
          mon_e = exp_w.pop_front();
          chk("w_data_shift", w_data, mon_e);
        end
        for (int r = ROWS - 1; r > 0; r--)
          for (int c = 0; c < COLS; c++) pe[r][c] = pe[r-1][c];
        for (int c = 0; c < COLS; c++) pe[0][c] = w_data[c*DW +: DW];
      end else begin
        chk("w_data_zero_outside_shift", w_data, 32'd0);
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          mon_d = exp_done.pop_front();
          mon_t = exp_tile.pop_front();
          chk("done_cycle", cyc, mon_d);
          chk("busy_during_done", 32'(busy), 32'd1);
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              chk($sformatf("pe_r%0d_c%0d", r, c), 32'(pe[r][c]), 32'(mon_t[r][c*DW +: DW]));
        end
      end
    end
  end

  // This task loads one tile with per-row stalls. A non-negative abort_k pulls reset during shift cycle abort_k.
  task automatic load_tile(input logic [3:0][31:0] rows, input logic [3:0][3:0] stalls,
                           input bit spur, input int abort_k);
    int n0, f;
    n0 = cyc;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    f = 0;
    for (int i = 0; i < ROWS; i++) begin
      for (int s = 0; s < int'(stalls[i]); s++) begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = $urandom;
        start = spur & 1'($urandom_range(0, 1));
        chk("s_ready_in_stall", 32'(s_if.s_ready), 32'd1);
        f++;
        @(posedge CLK); #1;
      end
      start = spur & 1'($urandom_range(0, 1));
      s_if.s_valid = 1'b1;
      s_if.s_data  = rows[i];
      chk("s_ready_in_fill", 32'(s_if.s_ready), 32'd1);
      chk("no_w_en_in_fill", 32'(w_en), 32'd0);
      f++;
      if (i == ROWS - 1) begin
        for (int k = 0; k < ROWS; k++)
          if (abort_k < 0 || k <= abort_k) exp_w.push_back(rows[ROWS-1-k]);
        if (abort_k < 0) begin
          // The start cycle counts as the first of the 1 + fill + ROWS + 1 cycles.
          exp_done.push_back(n0 + f + ROWS + 1);
          exp_tile.push_back(rows);
        end
      end
      @(posedge CLK); #1;
    end
    s_if.s_valid = 1'b0;
    s_if.s_data  = $urandom;
    start = 1'b0;
    chk("s_ready_drops_after_fill", 32'(s_if.s_ready), 32'd0);
    if (abort_k >= 0) begin
      repeat (abort_k) begin @(posedge CLK); #1; end
      RESET_N = 1'b0;
      @(posedge CLK); #1;
      chk("abort_w_en", 32'(w_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_array_en", 32'(array_en), 32'd0);
      chk("abort_s_ready", 32'(s_if.s_ready), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      RESET_N = 1'b1;
      return;
    end
    for (int t = 0; t < 50 && busy; t++) begin
      start = spur & 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    start = 1'b0;
    chk("busy_clears_in_time", 32'(busy), 32'd0);
  endtask

  logic [3:0][31:0] rows;
  logic [3:0][3:0]  stalls;
  int               v;

  initial begin
    RESET_N = 1'b0;
    start = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_w_data", w_data, 32'd0);
    chk("reset_w_en", 32'(w_en), 32'd0);
    chk("reset_array_en", 32'(array_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s_ready", 32'(s_if.s_ready), 32'd0);
    RESET_N = 1'b1;
    mon_on = 1'b1;
    @(posedge CLK); #1;

    rows = {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304};
    load_tile(rows, 16'h0000, 1'b0, -1);
    load_tile(rows, 16'h0300, 1'b0, -1);

    rows = {32'h7F7F7F7F, 32'h80808080, 32'h7F7F7F7F, 32'h80808080};
    load_tile(rows, 16'h0000, 1'b0, -1);
    v = int'($signed(pe[0][0]));
    chk("signed_min_kept", v, 32'hFFFF_FF80);
    v = int'($signed(pe[1][3]));
    chk("signed_max_kept", v, 32'h0000_007F);

    // These tiles run back to back. Spurious starts arrive in FILL, SHIFT and DONE, and each new start is issued the cycle after done.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < ROWS; i++) begin
        rows[i]   = $urandom;
        stalls[i] = 4'($urandom_range(0, 2));
      end
      load_tile(rows, stalls, 1'b1, -1);
      if (n % 3 == 2) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    rows = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};
    load_tile(rows, 16'h0010, 1'b0, 2);
    repeat (4) begin @(posedge CLK); #1; end
    chk("no_w_en_after_abort", 32'(w_en), 32'd0);

    rows = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    load_tile(rows, 16'h1020, 1'b1, -1);

    repeat (5) begin @(posedge CLK); #1; end
    chk("w_data_queue_drained", exp_w.size(), 32'd0);
    chk("done_queue_drained", exp_done.size(), 32'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
